// File: rtl/uncache_axi_bridge_pkg.sv
// uncache_axi_bridge_pkg
// Shared definitions for the uncached AXI bridge: FSM state encoding,
// fixed AXI4 field values and the default transaction ID.
package uncache_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [2:0] SIZE_4B        = 3'b010;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

    // SLVERR/DECERR are errors; EXOKAY (2'b01) is not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1] && (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/uncache_axi_bridge_if.sv
// uncache_axi_bridge_if
// Single-beat AXI4 bus between the uncached bridge (master) and the
// MMIO/confreg interconnect (slave).
//   AR/R : arid araddr arlen arsize arburst arlock arcache arprot arvalid
//          / arready ; rid rdata rresp rlast rvalid / rready
//   AW/W/B: awid awaddr ... awvalid / awready ; wid wdata wstrb wlast
//          wvalid / wready ; bid bresp bvalid / bready
interface uncache_axi_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [3:0]        wid;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/uncache_axi_bridge.sv
// uncache_axi_bridge
// Single-outstanding AXI4 master for uncached (MMIO/confreg) accesses.
// Turns one rd_req/wr_req word request into one AXI read or write and
// reports completion with a one-cycle reload pulse.
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   rd_req, rd_addr         read request (held until reload)
//   wr_req, wr_addr,
//   wr_data, wr_wstrb       write request (held until reload); wins over rd_req
//   reload                  one-cycle completion pulse
//   rd_data                 last read data, holds until the next read
//   bus_err                 pulses with reload on SLVERR/DECERR
//   axi                     AXI4 master port
//   dbg_state_o             current FSM state
//
// Handshake rule: a valid, once raised, stays high with its payload
// stable until the cycle where the matching ready is sampled high; the
// transfer happens on that clock edge. All outputs come from flops, so
// no AXI input reaches an output combinationally.
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [3:0]        wr_wstrb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic              reload,
    output logic [31:0]       rd_data,
    output logic              bus_err,
    uncache_axi_bridge_if.master axi,
    output state_e            dbg_state_o
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rd_data_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              aw_done_q, w_done_q;
    logic              reload_q, bus_err_q;

    logic aw_hs, w_hs;
    assign aw_hs = awvalid_q && axi.awready;
    assign w_hs  = wvalid_q  && axi.wready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_data_q <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            reload_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            reload_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        addr_q    <= wr_addr;
                        wdata_q   <= wr_data;
                        wstrb_q   <= wr_wstrb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= ST_WR;
                    end else if (rd_req) begin
                        addr_q    <= rd_addr;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // rid/rlast carry no information with one outstanding single beat.
                    if (axi.rvalid) begin
                        rready_q  <= 1'b0;
                        rd_data_q <= axi.rdata;
                        reload_q  <= 1'b1;
                        bus_err_q <= resp_is_err(axi.rresp);
                        state_q   <= ST_DONE;
                    end
                end
                ST_WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // AW and W may complete in either order or the same cycle.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q  <= 1'b0;
                        reload_q  <= 1'b1;
                        bus_err_q <= resp_is_err(axi.bresp);
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Upstream request is still high this cycle; it must not restart.
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = SIZE_4B;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;

    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    assign reload      = reload_q;
    assign bus_err     = bus_err_q;
    assign rd_data     = rd_data_q;
    assign dbg_state_o = state_q;

    logic unused_inputs;
    assign unused_inputs = ^{axi.rid, axi.rlast, axi.bid};

endmodule
